led_sequencer: RTL



---
 rtl/led_sequencer.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/led_sequencer.sv
// LED pattern controller on the CPU I/O bus.
// Static, blink, rotate and bounce patterns stepped by a programmable prescaler.
module led_sequencer #(
    parameter int PRESCALE_W = 24
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sel,
    input  logic [1:0]  addr,
    input  logic [31:0] wdata,
    input  logic        wstrb,
    input  logic        rstrb,
    output logic [31:0] rdata,
    output logic [7:0]  LED
);

    localparam logic [1:0] M_STATIC  = 2'd0;
    localparam logic [1:0] M_BLINK   = 2'd1;
    localparam logic [1:0] M_ROTATE  = 2'd2;
    localparam logic [1:0] M_BOUNCE  = 2'd3;

    localparam logic [1:0] A_CTRL    = 2'd0;
    localparam logic [1:0] A_PATTERN = 2'd1;
    localparam logic [1:0] A_PERIOD  = 2'd2;
    localparam logic [1:0] A_STATUS  = 2'd3;

    logic [1:0]            mode;
    logic                  enable;
    logic [7:0]            pattern;
    logic [PRESCALE_W-1:0] period;
    logic [PRESCALE_W-1:0] presc;
    logic [7:0]            shreg;
    logic                  dir;
    logic                  phase;
    logic [7:0]            stepcnt;

    logic                  wr_en;
    logic                  reload;
    logic                  period_wr;
    logic                  run;
    logic                  tick;
    logic [7:0]            shreg_nx;
    logic                  dir_nx;
    logic                  unused_bits;

    assign wr_en     = sel && wstrb;
    assign reload    = wr_en && (addr == A_CTRL || addr == A_PATTERN);
    assign period_wr = wr_en && (addr == A_PERIOD);
    assign run       = enable && (mode != M_STATIC);
    // A register write in the same cycle swallows the tick.
    assign tick      = run && (presc == period) && !reload && !period_wr;

    assign unused_bits = ^{rstrb, wdata[31:8]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode    <= M_STATIC;
            enable  <= 1'b0;
            pattern <= '0;
            period  <= '0;
        end else if (wr_en) begin
            unique case (addr)
                A_CTRL: begin
                    mode   <= wdata[1:0];
                    enable <= wdata[2];
                end
                A_PATTERN: pattern <= wdata[7:0];
                A_PERIOD:  period  <= wdata[PRESCALE_W-1:0];
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc <= '0;
        end else if (reload || period_wr || !run || tick) begin
            presc <= '0;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    always_comb begin
        shreg_nx = shreg;
        dir_nx   = dir;
        unique case (mode)
            M_ROTATE: shreg_nx = {shreg[6:0], shreg[7]};
            M_BOUNCE: begin
                if (!dir && shreg[7]) begin
                    dir_nx   = 1'b1;
                    shreg_nx = shreg >> 1;
                end else if (dir && shreg[0]) begin
                    dir_nx   = 1'b0;
                    shreg_nx = shreg << 1;
                end else begin
                    shreg_nx = dir ? (shreg >> 1) : (shreg << 1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg   <= '0;
            dir     <= 1'b0;
            phase   <= 1'b1;
            stepcnt <= '0;
        end else if (reload) begin
            shreg   <= (addr == A_PATTERN) ? wdata[7:0] : pattern;
            dir     <= 1'b0;
            phase   <= 1'b1;
            stepcnt <= '0;
        end else if (tick) begin
            shreg   <= shreg_nx;
            dir     <= dir_nx;
            phase   <= (mode == M_BLINK) ? ~phase : phase;
            stepcnt <= stepcnt + 8'd1;
        end
    end

    always_comb begin
        LED = pattern;
        unique case (mode)
            M_STATIC: LED = pattern;
            M_BLINK:  LED = phase ? pattern : 8'h00;
            M_ROTATE: LED = shreg;
            M_BOUNCE: LED = shreg;
            default:  LED = pattern;
        endcase
    end

    always_comb begin
        rdata = '0;
        if (sel) begin
            unique case (addr)
                A_CTRL:    rdata = {29'd0, enable, mode};
                A_PATTERN: rdata = {24'd0, pattern};
                A_PERIOD:  rdata = 32'(period);
                A_STATUS:  rdata = {8'd0, stepcnt, 6'd0, phase, dir, LED};
                default:   rdata = '0;
            endcase
        end
    end

endmodule
